// File: rtl/ub_cyclic_banked_buffer.sv
// Unified buffer for 2D stencil pipelines: cyclically banked storage in x/y with a
// registered read port, write-to-read forwarding, out-of-range flagging and frame tracking.
module ub_cyclic_banked_buffer #(
    parameter int WIDTH    = 16,
    parameter int CTRL_W   = 16,
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int BANKS_X  = 2,
    parameter int BANKS_Y  = 2,
    parameter int WR_OFF_X = 0,
    parameter int WR_OFF_Y = 0,
    parameter int RD_OFF_X = 0,
    parameter int RD_OFF_Y = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [2:0][CTRL_W-1:0] wr_ctrl,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    input  logic [2:0][CTRL_W-1:0] rd_ctrl,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   oob_err,
    output logic                   frame_done
);

    localparam int NUM_BANKS = BANKS_X * BANKS_Y;
    localparam int DEPTH     = (IMG_W * IMG_H) / NUM_BANKS;
    localparam int FRAME     = IMG_W * IMG_H;
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W     = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int LOG_BX    = $clog2(BANKS_X);
    localparam int LOG_BY    = $clog2(BANKS_Y);

    localparam logic [CTRL_W-1:0] MASK_X    = CTRL_W'(BANKS_X - 1);
    localparam logic [CTRL_W-1:0] MASK_Y    = CTRL_W'(BANKS_Y - 1);
    localparam logic [CTRL_W-1:0] ROW_WORDS = CTRL_W'(IMG_W / BANKS_X);
    localparam logic [CTRL_W-1:0] LIM_X     = CTRL_W'(IMG_W);
    localparam logic [CTRL_W-1:0] LIM_Y     = CTRL_W'(IMG_H);
    localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(FRAME - 1);

    typedef struct packed {
        logic              in_range;
        logic [BANK_W-1:0] bank;
        logic [ADDR_W-1:0] addr;
    } loc_t;

    // Bank factors are powers of two, so divide/modulo reduce to shift/mask.
    function automatic loc_t map_coord(input logic [CTRL_W-1:0] cx, input logic [CTRL_W-1:0] cy,
                                       input logic [CTRL_W-1:0] ox, input logic [CTRL_W-1:0] oy);
        logic [CTRL_W-1:0] x;
        logic [CTRL_W-1:0] y;
        loc_t              loc;
        x            = cx - ox;
        y            = cy - oy;
        loc.in_range = (x < LIM_X) && (y < LIM_Y);
        loc.bank     = BANK_W'((x & MASK_X) | ((y & MASK_Y) << LOG_BX));
        loc.addr     = ADDR_W'((x >> LOG_BX) + (y >> LOG_BY) * ROW_WORDS);
        return loc;
    endfunction

    loc_t wr_loc;
    loc_t rd_loc;
    logic wr_fire, rd_fire, wr_oob, rd_oob, fwd_hit;
    logic unused_ctrl;

    assign wr_loc      = map_coord(wr_ctrl[1], wr_ctrl[2], CTRL_W'(WR_OFF_X), CTRL_W'(WR_OFF_Y));
    assign rd_loc      = map_coord(rd_ctrl[1], rd_ctrl[2], CTRL_W'(RD_OFF_X), CTRL_W'(RD_OFF_Y));
    assign unused_ctrl = ^{wr_ctrl[0], rd_ctrl[0]};

    assign wr_fire = wr_en && wr_loc.in_range && !flush;
    assign rd_fire = rd_en && rd_loc.in_range && !flush;
    assign wr_oob  = wr_en && !wr_loc.in_range && !flush;
    assign rd_oob  = rd_en && !rd_loc.in_range && !flush;
    assign fwd_hit = wr_fire && (wr_loc.bank == rd_loc.bank) && (wr_loc.addr == rd_loc.addr);

    logic [WIDTH-1:0] mem [NUM_BANKS][DEPTH];
    logic [CNT_W-1:0] count;

    // NOTE: storage has no reset so it maps onto RAM macros; contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_loc.bank][wr_loc.addr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            oob_err    <= 1'b0;
            frame_done <= 1'b0;
            count      <= '0;
        end else if (flush) begin
            rd_valid   <= 1'b0;
            oob_err    <= 1'b0;
            frame_done <= 1'b0;
            count      <= '0;
        end else begin
            rd_valid   <= rd_en;
            frame_done <= 1'b0;
            if (rd_fire) begin
                rd_data <= fwd_hit ? wr_data : mem[rd_loc.bank][rd_loc.addr];
            end else if (rd_oob) begin
                rd_data <= '0;
            end
            if (wr_oob || rd_oob) oob_err <= 1'b1;
            if (wr_fire) begin
                if (count == LAST_PIX) begin
                    count      <= '0;
                    frame_done <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/ub_cyclic_banked_buffer.md
Name: ub_cyclic_banked_buffer

Overview:
- Parametrised unified buffer for 2D stencil pipelines. Generalises the fixed 4-bank, 16-bit buffer to configurable data width, image size and cyclic bank factors in x and y.
- Uses compact per-bank addressing. Adds a registered read port with valid, same-cycle write-to-read forwarding, out-of-range detection and frame-completion tracking.
- Sits between a producer compute op (write port) and a consumer compute op (read port). Both ports use the standard 3-entry loop control-variable vectors.

Parameters:
- WIDTH, 16, data word width.
- CTRL_W, 16, width of each control variable.
- IMG_W, 64, image width in pixels; must be divisible by BANKS_X.
- IMG_H, 64, image height in pixels; must be divisible by BANKS_Y.
- BANKS_X, 2, cyclic bank factor in x; power of two, >=1.
- BANKS_Y, 2, cyclic bank factor in y; power of two, >=1.
- WR_OFF_X, 0, x offset subtracted from the write coordinate.
- WR_OFF_Y, 0, y offset subtracted from the write coordinate.
- RD_OFF_X, 0, x offset subtracted from the read coordinate.
- RD_OFF_Y, 0, y offset subtracted from the read coordinate.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous soft clear of control state.
- wr_en  in  1  write request.
- wr_ctrl  in  3 x CTRL_W  write loop vars; [1]=x, [2]=y, [0] ignored.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request.
- rd_ctrl  in  3 x CTRL_W  read loop vars; [1]=x, [2]=y, [0] ignored.
- rd_data  out  WIDTH  registered read data.
- rd_valid  out  1  rd_data valid; one pulse per accepted read.
- oob_err  out  1  sticky out-of-range access flag.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.

Behaviour:
- Coordinates:
  - x = ctrl[1] - OFF_X, y = ctrl[2] - OFF_Y, computed modulo 2^CTRL_W (unsigned).
  - In range iff x < IMG_W and y < IMG_H. Negative results wrap to large values and are out of range.
- Bank mapping:
  - bank = (x % BANKS_X) + (y % BANKS_Y) * BANKS_X.
  - addr = (x / BANKS_X) + (y / BANKS_Y) * (IMG_W / BANKS_X).
  - Per-bank depth = IMG_W * IMG_H / (BANKS_X * BANKS_Y).
  - Divide and modulo are shift and mask only.
- Write:
  - When wr_en and in range, the selected bank[addr] is written with wr_data at the clk edge.
  - Exactly one bank is written per write.
- Read:
  - Latency 1. When rd_en and in range, rd_data is the selected bank[addr] and rd_valid = 1 in the next cycle.
  - When rd_en is low, rd_valid = 0 next cycle and rd_data holds its last value.
- Forwarding: if a read and a write hit the same (bank, addr) in the same cycle, rd_data next cycle equals wr_data. New data wins.
- Out-of-range access (either port):
  - The access is suppressed and oob_err is set next cycle; it stays set until flush or reset.
  - An out-of-range read still returns rd_valid = 1, with rd_data = 0.
- Frame counter:
  - Counts in-range writes, 0 .. IMG_W*IMG_H-1.
  - On the write that occurs at count = IMG_W*IMG_H-1, the count wraps to 0 and frame_done pulses high for exactly one cycle next cycle.
- Flush (synchronous, highest priority after reset):
  - Clears rd_valid, oob_err, frame_done and the count.
  - A read or write presented in a flush cycle is ignored.
  - Bank contents are preserved.
- Reset (asynchronous):
  - rd_data = 0, rd_valid = 0, oob_err = 0, frame_done = 0, count = 0, effective immediately, including mid-operation.
  - Bank contents are undefined after reset.
- No backpressure: reads and writes are accepted every cycle.

Test Plan:
- Write (3,5)=0xABCD (bank 3, addr 65), then read (3,5) the next cycle -> rd_valid=1 with rd_data=0xABCD one cycle after rd_en.
- Write (0,0)=1, (1,0)=2, (0,1)=3, (1,1)=4 -> banks 0..3, all at addr 0. Read back in reverse order -> 4,3,2,1 on consecutive cycles.
- (10,10) holds 0; in the same cycle write 0x1234 there and read it -> rd_data=0x1234 next cycle.
- Write x=64, y=0 with data 0x5555 -> no bank written, oob_err=1 next cycle, count unchanged. Pulse flush -> oob_err=0.
- 4096 in-range writes with default params -> frame_done=1 for exactly one cycle after the 4096th write, count=0. Write 4097 -> no pulse.
- Assert rst_n=0 mid-cycle while rd_valid=1 -> rd_valid=0, rd_data=0 and frame_done=0 immediately, without waiting for a clk edge.
